// File: rtl/int_dispq_reader.sv
// In-order integer dispatch queue, reader end: drains the oldest entries into the ALU/BRU/MDU reservation stations.
// Latency: one cycle from enqueue to earliest dequeue; dequeue selection is combinational from registered storage.
// Backpressure: each station's i_rs_free caps the entries sent to it, and the first blocked entry stalls every younger port.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   i_squash_vld      flush all entries; blocks dequeue and enqueue this cycle
//   o_can_enq         at least INPORT_NUM entries are free (from registered count only)
//   i_enq_vld/_data/_rsid   INPORT_NUM enqueue lanes; valid must be a prefix
//   i_rs_free         free slots per reservation station, RS_NUM fields of FW bits
//   o_deq_vld/_data/_rsid   OUTPORT_NUM dequeue ports; port k is the k-th oldest entry
module int_dispq_reader #(
    parameter int DEPTH       = 16,
    parameter int INPORT_NUM  = 4,
    parameter int OUTPORT_NUM = 4,
    parameter int RS_NUM      = 3,
    parameter int DWIDTH      = 64,
    localparam int RSW        = (RS_NUM > 1) ? $clog2(RS_NUM) : 1,
    localparam int FW         = $clog2(OUTPORT_NUM + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_squash_vld,
    output logic                          o_can_enq,
    input  logic [INPORT_NUM-1:0]         i_enq_vld,
    input  logic [INPORT_NUM*DWIDTH-1:0]  i_enq_data,
    input  logic [INPORT_NUM*RSW-1:0]     i_enq_rsid,
    input  logic [RS_NUM*FW-1:0]          i_rs_free,
    output logic [OUTPORT_NUM-1:0]        o_deq_vld,
    output logic [OUTPORT_NUM*DWIDTH-1:0] o_deq_data,
    output logic [OUTPORT_NUM*RSW-1:0]    o_deq_rsid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DWIDTH-1:0] data_q [DEPTH];
    logic [DWIDTH-1:0] data_d [DEPTH];
    logic [RSW-1:0]    rsid_q [DEPTH];
    logic [RSW-1:0]    rsid_d [DEPTH];

    logic              enq_fire;
    logic [CW-1:0]     nenq;
    logic [CW-1:0]     ndeq;
    logic [FW-1:0]     rs_free_arr [RS_NUM];
    logic [RSW-1:0]    cand_rsid   [OUTPORT_NUM];

    // Compares against the registered count only, so a dequeue in the same
    // cycle never opens the enqueue window early.
    assign o_can_enq = (CW'(DEPTH) - count_q) >= CW'(INPORT_NUM);

    always_comb begin
        for (int r = 0; r < RS_NUM; r++) begin
            rs_free_arr[r] = i_rs_free[r*FW +: FW];
        end
    end

    // Dequeue selection: in-order prefix of the oldest entries, each port
    // admitted only if its station still has room after the older ports that
    // target the same station.
    always_comb begin : deq_sel
        logic          chain;
        logic [FW-1:0] same;
        logic [FW-1:0] free_k;
        logic [PW-1:0] idx;
        o_deq_vld  = '0;
        o_deq_data = '0;
        o_deq_rsid = '0;
        ndeq       = '0;
        chain      = !i_squash_vld;
        for (int k = 0; k < OUTPORT_NUM; k++) begin
            idx          = head_q + PW'(k);
            cand_rsid[k] = rsid_q[idx];
        end
        for (int k = 0; k < OUTPORT_NUM; k++) begin
            idx = head_q + PW'(k);
            o_deq_data[k*DWIDTH +: DWIDTH] = data_q[idx];
            o_deq_rsid[k*RSW +: RSW]       = cand_rsid[k];
            same = '0;
            for (int j = 0; j < OUTPORT_NUM; j++) begin
                if (j <= k && cand_rsid[j] == cand_rsid[k]) begin
                    same = same + FW'(1);
                end
            end
            // An rsid outside the station range sees zero free slots.
            free_k = '0;
            for (int r = 0; r < RS_NUM; r++) begin
                if (cand_rsid[k] == RSW'(r)) begin
                    free_k = rs_free_arr[r];
                end
            end
            chain        = chain && (CW'(k) < count_q) && (same <= free_k);
            o_deq_vld[k] = chain;
            ndeq         = ndeq + CW'(chain);
        end
    end

    // Enqueue: lane k lands in slot tail+k; pointer arithmetic wraps
    // naturally because DEPTH is a power of two.
    always_comb begin : enq_wr
        logic [PW-1:0] idx;
        enq_fire = o_can_enq && !i_squash_vld;
        nenq     = '0;
        data_d   = data_q;
        rsid_d   = rsid_q;
        for (int k = 0; k < INPORT_NUM; k++) begin
            idx = tail_q + PW'(k);
            if (enq_fire && i_enq_vld[k]) begin
                data_d[idx] = i_enq_data[k*DWIDTH +: DWIDTH];
                rsid_d[idx] = i_enq_rsid[k*RSW +: RSW];
                nenq        = nenq + CW'(1);
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (i_squash_vld) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(ndeq);
            tail_d  = tail_q + PW'(nenq);
            count_d = count_q + nenq - ndeq;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: validity is tracked by count alone.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        rsid_q <= rsid_d;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (|i_enq_vld) begin
                assert (o_can_enq)
                else $warning("enqueue dropped: fewer than INPORT_NUM free entries");
            end
            assert ((i_enq_vld & (i_enq_vld + INPORT_NUM'(1))) == '0)
            else $error("i_enq_vld is not a contiguous prefix");
        end
    end
`endif

endmodule

// File: tb/tb_int_dispq_reader.sv
module tb_int_dispq_reader;

    logic         clk = 1'b0;
    logic         rst;
    logic         squash;
    logic         can_enq;
    logic [3:0]   enq_vld;
    logic [255:0] enq_data;
    logic [7:0]   enq_rsid;
    logic [8:0]   rs_free;
    logic [3:0]   deq_vld;
    logic [255:0] deq_data;
    logic [7:0]   deq_rsid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    int_dispq_reader dut (
        .clk          (clk),
        .rst          (rst),
        .i_squash_vld (squash),
        .o_can_enq    (can_enq),
        .i_enq_vld    (enq_vld),
        .i_enq_data   (enq_data),
        .i_enq_rsid   (enq_rsid),
        .i_rs_free    (rs_free),
        .o_deq_vld    (deq_vld),
        .o_deq_data   (deq_data),
        .o_deq_rsid   (deq_rsid)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_enq(input logic [3:0] v, input logic [63:0] base, input logic [7:0] rs);
        enq_vld = v;
        for (int k = 0; k < 4; k++) enq_data[k*64 +: 64] = base + 64'(k);
        enq_rsid = rs;
    endtask

    task automatic set_free(input int f0, input int f1, input int f2);
        rs_free = {3'(f2), 3'(f1), 3'(f0)};
    endtask

    task automatic check_data(input string tag, input int k, input logic [63:0] exp);
        check(tag, deq_data[k*64 +: 64], exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int mq_seq[$];
        int mq_rs[$];
        int sent;
        int recv;
        int recv_dut;
        int f[3];
        int used[3];
        int nexp;
        int n;
        bit stop;

        rst    = 1'b1;
        squash = 1'b0;
        set_enq(4'b0000, 64'd0, 8'd0);
        set_free(0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset then idle
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("idle_can_enq", can_enq, 1);
            check("idle_deq_vld", deq_vld, 0);
            check("idle_count", dut.count_q, 0);
        end

        // Four entries, rsid 0,1,0,2, enough room everywhere
        @(negedge clk);
        set_enq(4'b1111, 64'd100, {2'd2, 2'd0, 2'd1, 2'd0});
        #1 check("t1_no_bypass", deq_vld, 0);
        @(negedge clk);
        set_enq(4'b0000, 64'd0, 8'd0);
        set_free(2, 2, 2);
        #1 check("t1_vld", deq_vld, 4'b1111);
        for (int k = 0; k < 4; k++) check_data("t1_data", k, 64'd100 + 64'(k));
        check("t1_rsid", deq_rsid, 8'b10_00_01_00);
        @(negedge clk);
        set_free(0, 0, 0);
        #1 check("t1_empty", dut.count_q, 0);
        check("t1_empty_vld", deq_vld, 0);

        // Station 0 has one slot: the second rsid-0 entry blocks the tail
        @(negedge clk);
        set_enq(4'b1111, 64'd200, {2'd2, 2'd0, 2'd1, 2'd0});
        @(negedge clk);
        set_enq(4'b0000, 64'd0, 8'd0);
        set_free(1, 2, 2);
        #1 check("t2_vld_a", deq_vld, 4'b0011);
        check_data("t2_data_a0", 0, 64'd200);
        check_data("t2_data_a1", 1, 64'd201);
        @(negedge clk); #1;
        check("t2_vld_b", deq_vld, 4'b0011);
        check_data("t2_data_b0", 0, 64'd202);
        check_data("t2_data_b1", 1, 64'd203);
        check("t2_rsid_b", deq_rsid[3:0], 4'b10_00);
        @(negedge clk);
        set_free(0, 0, 0);
        #1 check("t2_empty", dut.count_q, 0);

        // Fill to 13 entries, overflow attempt, then free one slot
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_enq(4'b1111, 64'd300 + 64'(4*i), 8'd0);
            #1 check("t3_can_enq_fill", can_enq, 1);
        end
        @(negedge clk);
        set_enq(4'b0001, 64'd312, 8'd0);
        #1 check("t3_can_enq_12", can_enq, 1);
        @(negedge clk);
        set_enq(4'b0000, 64'd0, 8'd0);
        #1 check("t3_can_enq_13", can_enq, 0);
        check("t3_count_13", dut.count_q, 13);
        @(negedge clk);
        set_enq(4'b1111, 64'd400, 8'd0);
        #1 check("t3_can_enq_full", can_enq, 0);
        @(negedge clk);
        set_enq(4'b0000, 64'd0, 8'd0);
        set_free(1, 0, 0);
        #1 check("t3_overflow_ignored", dut.count_q, 13);
        check("t3_deq1_vld", deq_vld, 4'b0001);
        check_data("t3_deq1_data", 0, 64'd300);
        check("t3_can_enq_same_cycle", can_enq, 0);
        @(negedge clk);
        set_free(4, 4, 4);
        #1 check("t3_count_12", dut.count_q, 12);
        check("t3_can_enq_12b", can_enq, 1);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) begin
                @(negedge clk); #1;
            end
            check("t3_drain_vld", deq_vld, 4'b1111);
            for (int k = 0; k < 4; k++) check_data("t3_drain_data", k, 64'd301 + 64'(4*c + k));
        end
        @(negedge clk);
        set_free(0, 0, 0);
        #1 check("t3_empty", dut.count_q, 0);

        // Stream 40 entries across pointer wrap with random station room
        sent = 0;
        recv = 0;
        recv_dut = 0;
        for (int cyc = 0; cyc < 200 && recv < 40; cyc++) begin
            @(negedge clk);
            for (int r = 0; r < 3; r++) f[r] = int'($urandom_range(0, 4));
            set_free(f[0], f[1], f[2]);
            n = (16 - mq_seq.size() >= 4 && sent < 40) ? ((40 - sent < 4) ? 40 - sent : 4) : 0;
            enq_vld = '0;
            for (int k = 0; k < 4; k++) begin
                enq_data[k*64 +: 64] = 64'd0;
                enq_rsid[k*2 +: 2]   = 2'd0;
            end
            for (int k = 0; k < n; k++) begin
                int rs;
                rs = int'($urandom_range(0, 2));
                enq_vld[k]           = 1'b1;
                enq_data[k*64 +: 64] = 64'd1000 + 64'(sent + k);
                enq_rsid[k*2 +: 2]   = 2'(rs);
            end
            #1;
            for (int r = 0; r < 3; r++) used[r] = 0;
            nexp = 0;
            stop = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (!stop && k < mq_seq.size() && used[mq_rs[k]] < f[mq_rs[k]]) begin
                    used[mq_rs[k]]++;
                    nexp++;
                end else begin
                    stop = 1'b1;
                end
            end
            check("t4_can_enq", can_enq, (16 - mq_seq.size() >= 4) ? 1 : 0);
            check("t4_vld", deq_vld, 64'((1 << nexp) - 1));
            for (int k = 0; k < nexp; k++) begin
                check_data("t4_data", k, 64'd1000 + 64'(recv + k));
                check("t4_rsid", deq_rsid[k*2 +: 2], 64'(mq_rs[k]));
            end
            for (int k = 0; k < 4; k++) recv_dut += int'(deq_vld[k]);
            for (int k = 0; k < nexp; k++) begin
                void'(mq_seq.pop_front());
                void'(mq_rs.pop_front());
            end
            recv += nexp;
            for (int k = 0; k < n; k++) begin
                mq_seq.push_back(sent + k);
                mq_rs.push_back(int'(enq_rsid[k*2 +: 2]));
            end
            sent += n;
        end
        @(negedge clk);
        set_enq(4'b0000, 64'd0, 8'd0);
        set_free(0, 0, 0);
        #1 check("t4_recv_total", 64'(recv_dut), 64'd40);
        check("t4_count_end", dut.count_q, 0);

        // Squash with 8 entries held and a concurrent enqueue
        @(negedge clk);
        set_enq(4'b1111, 64'd500, 8'd0);
        @(negedge clk);
        set_enq(4'b1111, 64'd504, 8'd0);
        @(negedge clk);
        set_enq(4'b0000, 64'd0, 8'd0);
        #1 check("t5_count_8", dut.count_q, 8);
        @(negedge clk);
        squash = 1'b1;
        set_enq(4'b1111, 64'd600, 8'd0);
        set_free(4, 4, 4);
        #1 check("t5_squash_vld", deq_vld, 0);
        @(negedge clk);
        squash = 1'b0;
        set_enq(4'b0000, 64'd0, 8'd0);
        #1 check("t5_count_0", dut.count_q, 0);
        check("t5_can_enq", can_enq, 1);
        check("t5_no_ghost", deq_vld, 0);
        @(negedge clk);
        set_enq(4'b0001, 64'd900, 8'b01);
        @(negedge clk);
        set_enq(4'b0000, 64'd0, 8'd0);
        #1 check("t5_after_vld", deq_vld, 4'b0001);
        check_data("t5_after_data", 0, 64'd900);
        check("t5_after_rsid", deq_rsid[1:0], 1);
        @(negedge clk); #1;
        check("t5_after_empty", dut.count_q, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
